// File: rtl/collision_life_tracker_pkg.sv
// Shared types and default constants for the collision/life tracker and the game state machine.
package game_pkg;

    typedef enum logic [1:0] {
        RELEASE_NULL = 2'b00,
        ON_LEFT      = 2'b01,
        ON_MID       = 2'b10,
        ON_RIGHT     = 2'b11
    } lane_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        APPROACH = 2'b01,
        WINDOW   = 2'b10,
        DONE     = 2'b11
    } chan_state_t;

    localparam int DEF_START_LIVES     = 3;
    localparam int DEF_APPROACH_FRAMES = 48;
    localparam int DEF_HIT_WINDOW      = 4;
    localparam int DEF_INVULN_FRAMES   = 60;
    localparam int DEF_SCORE_W         = 8;

    localparam int Y_W     = 6;
    localparam int WCNT_W  = 4;
    localparam int INV_W   = 8;
    localparam int LIVES_W = 3;

    // A released object can only meet the penguin when both sit on a real lane.
    function automatic logic lane_match(input lane_t obj_lane, input lane_t player_lane);
        return (obj_lane != RELEASE_NULL) && (obj_lane == player_lane);
    endfunction

endpackage

// File: rtl/collision_life_tracker_if.sv
// Object-release / collision-result bundle between the game state machine and the tracker.
interface collision_life_tracker_if #(
    parameter int SCORE_W = 8
);
    import game_pkg::*;

    logic                   GAME_SWITCH;
    lane_t                  RELEASE_BARRIER;
    lane_t                  RELEASE_COIN;
    lane_t                  PLAYER_LANE;
    logic                   PLAYER_JUMP;
    logic                   PENGUIN_HIT;
    logic                   COIN_HIT;
    logic                   ZERO_LIVES;
    logic [LIVES_W-1:0]     LIVES;
    logic [SCORE_W-1:0]     COIN_SCORE;
    logic [Y_W-1:0]         BARRIER_Y;
    logic [Y_W-1:0]         COIN_Y;

    modport master (
        output GAME_SWITCH, RELEASE_BARRIER, RELEASE_COIN, PLAYER_LANE, PLAYER_JUMP,
        input  PENGUIN_HIT, COIN_HIT, ZERO_LIVES, LIVES, COIN_SCORE, BARRIER_Y, COIN_Y
    );

    modport slave (
        input  GAME_SWITCH, RELEASE_BARRIER, RELEASE_COIN, PLAYER_LANE, PLAYER_JUMP,
        output PENGUIN_HIT, COIN_HIT, ZERO_LIVES, LIVES, COIN_SCORE, BARRIER_Y, COIN_Y
    );

endinterface

// File: rtl/collision_life_tracker_channel.sv
// One released object: approach position, hit-window timing and collision test.
module object_channel
    import game_pkg::*;
#(
    parameter bit IS_BARRIER      = 1'b0,
    parameter int APPROACH_FRAMES = DEF_APPROACH_FRAMES,
    parameter int HIT_WINDOW      = DEF_HIT_WINDOW
)(
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_adv,
    input  lane_t          i_release,
    input  lane_t          i_player_lane,
    input  logic           i_player_jump,
    input  logic           i_invuln_zero,
    output logic [Y_W-1:0] o_y,
    output logic           o_collide
);

    localparam logic [Y_W-1:0]    LP_Y_END    = Y_W'(APPROACH_FRAMES);
    localparam logic [WCNT_W-1:0] LP_WIN_LAST = WCNT_W'(HIT_WINDOW - 1);
    localparam logic [Y_W-1:0]    LP_Y_ONE    = Y_W'(1'b1);
    localparam logic [WCNT_W-1:0] LP_W_ONE    = WCNT_W'(1'b1);

    chan_state_t       r_state;
    chan_state_t       w_state_nxt;
    lane_t             r_lane;
    lane_t             w_lane_nxt;
    logic [Y_W-1:0]    r_y;
    logic [Y_W-1:0]    w_y_nxt;
    logic [Y_W-1:0]    w_y_inc;
    logic [WCNT_W-1:0] r_wcnt;
    logic [WCNT_W-1:0] w_wcnt_nxt;
    logic              w_release_on;
    logic              w_clear;
    logic              w_collide;

    assign w_release_on = (i_release != RELEASE_NULL);
    assign w_y_inc      = r_y + LP_Y_ONE;

    // State, latched lane, position and window counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_lane  <= RELEASE_NULL;
            r_y     <= {Y_W{1'b0}};
            r_wcnt  <= {WCNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
            r_y     <= w_y_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    // Collision strobe; barriers are dodged by jumping and ignored while invulnerable.
    always_comb begin
        w_clear   = 1'b1;
        w_collide = 1'b0;
        if (IS_BARRIER) begin
            w_clear = ~i_player_jump & i_invuln_zero;
        end else begin
            w_clear = 1'b1;
        end
        if (i_adv && (r_state == WINDOW) && w_release_on) begin
            w_collide = lane_match(r_lane, i_player_lane) & w_clear;
        end else begin
            w_collide = 1'b0;
        end
    end

    // Next-state logic; a release code of 00 aborts any object still in flight.
    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_y_nxt     = r_y;
        w_wcnt_nxt  = r_wcnt;
        if (i_adv) begin
            case (r_state)
                IDLE: begin
                    if (w_release_on) begin
                        w_state_nxt = APPROACH;
                        w_lane_nxt  = i_release;
                        w_y_nxt     = {Y_W{1'b0}};
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                APPROACH: begin
                    if (!w_release_on) begin
                        w_state_nxt = IDLE;
                        w_y_nxt     = {Y_W{1'b0}};
                    end else if (w_y_inc == LP_Y_END) begin
                        w_state_nxt = WINDOW;
                        w_y_nxt     = w_y_inc;
                        w_wcnt_nxt  = {WCNT_W{1'b0}};
                    end else begin
                        w_y_nxt     = w_y_inc;
                    end
                end
                WINDOW: begin
                    if (!w_release_on) begin
                        w_state_nxt = IDLE;
                        w_y_nxt     = {Y_W{1'b0}};
                    end else if (w_collide || (r_wcnt == LP_WIN_LAST)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_wcnt_nxt  = r_wcnt + LP_W_ONE;
                    end
                end
                DONE: begin
                    if (!w_release_on) begin
                        w_state_nxt = IDLE;
                        w_y_nxt     = {Y_W{1'b0}};
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_y_nxt     = {Y_W{1'b0}};
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    assign o_y       = r_y;
    assign o_collide = w_collide;

endmodule

// File: rtl/collision_life_tracker.sv
// Frame-tick generation, barrier/coin channels, and lives, score and invulnerability bookkeeping.
module collision_life_tracker
    import game_pkg::*;
#(
    parameter int START_LIVES     = DEF_START_LIVES,
    parameter int APPROACH_FRAMES = DEF_APPROACH_FRAMES,
    parameter int HIT_WINDOW      = DEF_HIT_WINDOW,
    parameter int INVULN_FRAMES   = DEF_INVULN_FRAMES,
    parameter int SCORE_W         = DEF_SCORE_W
)(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_v_sync,
    collision_life_tracker_if.slave io_bus
);

    localparam logic [LIVES_W-1:0] LP_START_LIVES = LIVES_W'(START_LIVES);
    localparam logic [INV_W-1:0]   LP_INVULN      = INV_W'(INVULN_FRAMES);
    localparam logic [SCORE_W-1:0] LP_SCORE_MAX   = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] LP_SCORE_ONE   = SCORE_W'(1'b1);

    logic               r_vs_meta;
    logic               r_vs_sync;
    logic               r_vs_prev;
    logic [LIVES_W-1:0] r_lives;
    logic [INV_W-1:0]   r_invuln;
    logic               r_zero_lives;
    logic [SCORE_W-1:0] r_score;
    logic               r_penguin_hit;
    logic               r_coin_hit;

    logic               w_tick;
    logic               w_adv;
    logic               w_invuln_zero;
    logic               w_bar_collide;
    logic               w_coin_collide;
    logic [Y_W-1:0]     w_barrier_y;
    logic [Y_W-1:0]     w_coin_y;

    // Bring the VGA vertical sync into the clock domain and keep the previous level for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= i_v_sync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_tick        = r_vs_sync & ~r_vs_prev;
    assign w_adv         = w_tick & io_bus.GAME_SWITCH & ~r_zero_lives;
    assign w_invuln_zero = (r_invuln == {INV_W{1'b0}});

    object_channel #(
        .IS_BARRIER      (1'b1),
        .APPROACH_FRAMES (APPROACH_FRAMES),
        .HIT_WINDOW      (HIT_WINDOW)
    ) u_barrier (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_adv           (w_adv),
        .i_release       (io_bus.RELEASE_BARRIER),
        .i_player_lane   (io_bus.PLAYER_LANE),
        .i_player_jump   (io_bus.PLAYER_JUMP),
        .i_invuln_zero   (w_invuln_zero),
        .o_y             (w_barrier_y),
        .o_collide       (w_bar_collide)
    );

    object_channel #(
        .IS_BARRIER      (1'b0),
        .APPROACH_FRAMES (APPROACH_FRAMES),
        .HIT_WINDOW      (HIT_WINDOW)
    ) u_coin (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_adv           (w_adv),
        .i_release       (io_bus.RELEASE_COIN),
        .i_player_lane   (io_bus.PLAYER_LANE),
        .i_player_jump   (io_bus.PLAYER_JUMP),
        .i_invuln_zero   (1'b1),
        .o_y             (w_coin_y),
        .o_collide       (w_coin_collide)
    );

    // Lives, invulnerability countdown and the sticky out-of-lives flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lives      <= LP_START_LIVES;
            r_invuln     <= {INV_W{1'b0}};
            r_zero_lives <= 1'b0;
        end else if (w_adv && w_bar_collide) begin
            r_lives      <= (r_lives == 3'd0) ? 3'd0 : (r_lives - 3'd1);
            r_invuln     <= LP_INVULN;
            r_zero_lives <= (r_lives <= 3'd1);
        end else if (w_adv && !w_invuln_zero) begin
            r_invuln     <= r_invuln - 8'd1;
        end
    end

    // Saturating coin score.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_score <= {SCORE_W{1'b0}};
        end else if (w_adv && w_coin_collide && (r_score != LP_SCORE_MAX)) begin
            r_score <= r_score + LP_SCORE_ONE;
        end
    end

    // Hit flags last one whole frame: every tick reloads them, even when the game is frozen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_penguin_hit <= 1'b0;
            r_coin_hit    <= 1'b0;
        end else if (w_tick) begin
            r_penguin_hit <= w_bar_collide;
            r_coin_hit    <= w_coin_collide;
        end
    end

    assign io_bus.PENGUIN_HIT = r_penguin_hit;
    assign io_bus.COIN_HIT    = r_coin_hit;
    assign io_bus.ZERO_LIVES  = r_zero_lives;
    assign io_bus.LIVES       = r_lives;
    assign io_bus.COIN_SCORE  = r_score;
    assign io_bus.BARRIER_Y   = w_barrier_y;
    assign io_bus.COIN_Y      = w_coin_y;

endmodule

// File: tb/tb_collision_life_tracker.sv
// Scoreboard bench: each frame pushes its expected outputs, a monitor pops and checks after the tick.
`timescale 1ns/1ps
module tb_collision_life_tracker;
    import game_pkg::*;

    typedef struct packed {
        logic       chk;
        logic       ph;
        logic       ch;
        logic       zl;
        logic [2:0] lv;
        logic [7:0] sc;
        logic [5:0] by;
        logic [5:0] cy;
    } exp_t;

    localparam exp_t NC = '0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic vs    = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    collision_life_tracker_if #(.SCORE_W(8)) bus();

    collision_life_tracker #(
        .START_LIVES(3), .APPROACH_FRAMES(48), .HIT_WINDOW(4), .INVULN_FRAMES(60), .SCORE_W(8)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_v_sync (vs),
        .io_bus   (bus)
    );

    function automatic exp_t mk(input logic ph, input logic ch, input logic zl,
                                input int lv, input int sc, input int by, input int cy);
        exp_t e;
        e.chk = 1'b1;
        e.ph  = ph;
        e.ch  = ch;
        e.zl  = zl;
        e.lv  = 3'(lv);
        e.sc  = 8'(sc);
        e.by  = 6'(by);
        e.cy  = 6'(cy);
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        cmp({tag, ".PENGUIN_HIT"}, 32'(bus.PENGUIN_HIT), 32'(e.ph));
        cmp({tag, ".COIN_HIT"},    32'(bus.COIN_HIT),    32'(e.ch));
        cmp({tag, ".ZERO_LIVES"},  32'(bus.ZERO_LIVES),  32'(e.zl));
        cmp({tag, ".LIVES"},       32'(bus.LIVES),       32'(e.lv));
        cmp({tag, ".COIN_SCORE"},  32'(bus.COIN_SCORE),  32'(e.sc));
        cmp({tag, ".BARRIER_Y"},   32'(bus.BARRIER_Y),   32'(e.by));
        cmp({tag, ".COIN_Y"},      32'(bus.COIN_Y),      32'(e.cy));
    endtask

    // One video frame: queue the expectation, then a v_sync pulse of 4 high / 4 low clocks.
    task automatic frame(input exp_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        vs = 1'b1;
        repeat (4) @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check_all(tag, mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor: outputs settle a few clocks after each v_sync rise; compare against the queued frame.
    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(posedge vs);
            repeat (5) @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor: frame with no queued expectation, queue size %0d, want >0", exp_q.size());
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.chk) check_all(nm, e);
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.GAME_SWITCH     = 1'b1;
        bus.RELEASE_BARRIER = RELEASE_NULL;
        bus.RELEASE_COIN    = RELEASE_NULL;
        bus.PLAYER_LANE     = RELEASE_NULL;
        bus.PLAYER_JUMP     = 1'b0;
        #3;
        apply_reset("reset0");

        // Coin in the middle lane, penguin in the middle lane.
        bus.RELEASE_COIN = ON_MID;
        bus.PLAYER_LANE  = ON_MID;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 0), "t1_release");
        for (int i = 1; i <= 48; i++) frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, i), "t1_approach");
        frame(mk(1'b0, 1'b1, 1'b0, 3, 1, 0, 48), "t1_coin_hit");
        frame(mk(1'b0, 1'b0, 1'b0, 3, 1, 0, 48), "t1_hit_clear");
        frame(mk(1'b0, 1'b0, 1'b0, 3, 1, 0, 48), "t1_done_wait");
        bus.RELEASE_COIN = RELEASE_NULL;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 1, 0, 0), "t1_done_idle");

        // Barrier hit in the left lane, then the same barrier dodged by jumping.
        bus.RELEASE_BARRIER = ON_LEFT;
        bus.PLAYER_LANE     = ON_LEFT;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 1, 0, 0), "t2_release");
        repeat (47) frame(NC, "");
        frame(mk(1'b0, 1'b0, 1'b0, 3, 1, 48, 0), "t2_arrive");
        frame(mk(1'b1, 1'b0, 1'b0, 2, 1, 48, 0), "t2_barrier_hit");
        bus.RELEASE_BARRIER = RELEASE_NULL;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, 0), "t2_hit_clear");
        repeat (12) frame(NC, "");
        bus.RELEASE_BARRIER = ON_LEFT;
        bus.PLAYER_JUMP     = 1'b1;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, 0), "t2_jump_release");
        repeat (47) frame(NC, "");
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 48, 0), "t2_jump_arrive");
        repeat (4) frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 48, 0), "t2_jump_window");
        bus.PLAYER_JUMP = 1'b0;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 48, 0), "t2_jump_done");
        bus.RELEASE_BARRIER = RELEASE_NULL;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, 0), "t2_jump_idle");

        // Second barrier reaches the penguin while still invulnerable.
        apply_reset("reset3");
        bus.RELEASE_BARRIER = ON_LEFT;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 0), "t3_release");
        repeat (47) frame(NC, "");
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 48, 0), "t3_arrive");
        frame(mk(1'b1, 1'b0, 1'b0, 2, 0, 48, 0), "t3_first_hit");
        frame(mk(1'b0, 1'b0, 1'b0, 2, 0, 48, 0), "t3_done_hold");
        bus.RELEASE_BARRIER = RELEASE_NULL;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 0, 0, 0), "t3_idle");
        bus.RELEASE_BARRIER = ON_LEFT;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 0, 0, 0), "t3_release2");
        repeat (47) frame(NC, "");
        frame(mk(1'b0, 1'b0, 1'b0, 2, 0, 48, 0), "t3_arrive2");
        repeat (4) frame(mk(1'b0, 1'b0, 1'b0, 2, 0, 48, 0), "t3_invuln_window");
        frame(mk(1'b0, 1'b0, 1'b0, 2, 0, 48, 0), "t3_miss_done");

        // Three well-spaced hits exhaust the lives and freeze the game.
        apply_reset("reset4");
        for (int k = 0; k < 3; k++) begin
            bus.RELEASE_BARRIER = ON_LEFT;
            frame(NC, "");
            repeat (47) frame(NC, "");
            frame(mk(1'b0, 1'b0, 1'b0, 3 - k, 0, 48, 0), "t4_arrive");
            frame(mk(1'b1, 1'b0, (k == 2), 2 - k, 0, 48, 0), "t4_hit");
            bus.RELEASE_BARRIER = RELEASE_NULL;
            frame((k == 2) ? mk(1'b0, 1'b0, 1'b1, 0, 0, 48, 0)
                           : mk(1'b0, 1'b0, 1'b0, 2 - k, 0, 0, 0), "t4_after_hit");
            repeat (12) frame(NC, "");
        end
        bus.RELEASE_BARRIER = ON_LEFT;
        bus.RELEASE_COIN    = ON_LEFT;
        repeat (5) frame(mk(1'b0, 1'b0, 1'b1, 0, 0, 48, 0), "t4_frozen");

        // Barrier and coin collide on the same tick, then a coin aborted mid-approach.
        bus.RELEASE_BARRIER = RELEASE_NULL;
        bus.RELEASE_COIN    = RELEASE_NULL;
        apply_reset("reset5");
        bus.RELEASE_BARRIER = ON_RIGHT;
        bus.RELEASE_COIN    = ON_RIGHT;
        bus.PLAYER_LANE     = ON_RIGHT;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 0), "t5_release");
        repeat (47) frame(NC, "");
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 48, 48), "t5_arrive");
        frame(mk(1'b1, 1'b1, 1'b0, 2, 1, 48, 48), "t5_double_hit");
        bus.RELEASE_BARRIER = RELEASE_NULL;
        bus.RELEASE_COIN    = RELEASE_NULL;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, 0), "t5_idle");
        bus.RELEASE_COIN = ON_LEFT;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, 0), "t5_coin_release");
        for (int i = 1; i <= 10; i++) frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, i), "t5_coin_approach");
        bus.RELEASE_COIN = RELEASE_NULL;
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, 0), "t5_abort");
        frame(mk(1'b0, 1'b0, 1'b0, 2, 1, 0, 0), "t5_abort_idle");

        // Freeze mid-approach, resume, then reset while the coin is in its window.
        apply_reset("reset6");
        bus.RELEASE_COIN = ON_MID;
        bus.PLAYER_LANE  = ON_MID;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 0), "t6_release");
        for (int i = 1; i <= 19; i++)
            frame((i == 19) ? mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 19) : NC, "t6_count");
        bus.GAME_SWITCH = 1'b0;
        repeat (20) frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 19), "t6_frozen");
        bus.GAME_SWITCH = 1'b1;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 20), "t6_resume");
        for (int i = 21; i <= 48; i++)
            frame((i == 48) ? mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 48) : NC, "t6_arrive");
        bus.PLAYER_LANE = ON_LEFT;
        frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 48), "t6_window_miss");
        bus.RELEASE_COIN = RELEASE_NULL;
        apply_reset("t6_reset_in_window");
        bus.PLAYER_LANE = ON_MID;
        repeat (3) frame(mk(1'b0, 1'b0, 1'b0, 3, 0, 0, 0), "t6_after_reset");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
